// File: rtl/mcs4_ram_chip_pkg.sv
// mcs4_ram_chip_pkg: shared MCS-4 bus types, RAM geometry and I/O-RAM opcode helpers
package mcs4_ram_chip_pkg;
    localparam int Ram_regs_per_chip  = 4;
    localparam int Ram_chars_per_reg  = 16;
    localparam int Ram_status_per_reg = 4;
    typedef logic [3:0] char_t;
    typedef logic [1:0] ram_chip_sel_t;
    typedef logic [1:0] ram_reg_sel_t;
    typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} instr_cyc_t;
    typedef enum logic [3:0] {
        WRM, WMP, WRR, OPA_UNDEF,
        WR0, WR1, WR2, WR3,
        SBM, RDM, RDR, ADM,
        RD0, RD1, RD2, RD3
    } ioram_opa_t;
    typedef struct packed {
        ram_chip_sel_t chip;
        ram_reg_sel_t  rreg;
    } ram_src_hi_t;
    function automatic logic ram_opa_is_read(ioram_opa_t o);
        return o inside {SBM, RDM, ADM, RD0, RD1, RD2, RD3};
    endfunction
    function automatic logic ram_opa_is_write(ioram_opa_t o);
        return o inside {WRM, WMP, WR0, WR1, WR2, WR3};
    endfunction
endpackage

// File: rtl/mcs4_cycle_tracker.sv
// mcs4_cycle_tracker: follows the 8-phase instruction cycle from sync; locks on the first sync
module mcs4_cycle_tracker
    import mcs4_ram_chip_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    output instr_cyc_t phase,
    output logic       locked
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= A1;
            locked <= 1'b0;
        end else begin
            locked <= locked | sync;
            phase  <= (sync || phase == X3) ? A1 : instr_cyc_t'(phase + 3'd1);
        end
    end
endmodule

// File: rtl/mcs4_ram_chip.sv
// mcs4_ram_chip: bus-side model of one 4002-style RAM chip (SRC decode, I/O-RAM execute, read drive)
module mcs4_ram_chip
    import mcs4_ram_chip_pkg::*;
#(
    parameter logic [1:0] Chip_id = 2'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    input  logic       cm_ram,
    input  logic [3:0] data_in,
    output logic [3:0] data_out,
    output logic       data_oe,
    output logic [3:0] port_out
);
    instr_cyc_t   phase;
    logic         locked;
    char_t        data [Ram_regs_per_chip][Ram_chars_per_reg];
    char_t        status [Ram_regs_per_chip][Ram_status_per_reg];
    ram_reg_sel_t src_reg;
    char_t        src_char;
    ioram_opa_t   opa;
    logic         selected, io_pending, src_hi;
    logic         abort, go, exec, rd_now;
    char_t        rd_val;
    ram_src_hi_t  src_hi_in;

    mcs4_cycle_tracker u_trk (
        .clk   (clk),
        .rst   (rst),
        .sync  (sync),
        .phase (phase),
        .locked(locked)
    );

    assign src_hi_in = ram_src_hi_t'(data_in);
    // A sync outside X3 kills whatever this cycle would have decoded or executed
    assign abort  = locked && sync && phase != X3;
    assign go     = locked && !abort;
    assign exec   = go && io_pending && selected;
    assign rd_now = exec && phase == X1 && ram_opa_is_read(opa);
    assign rd_val = opa[3:2] == 2'b11 ? status[src_reg][opa[1:0]] : data[src_reg][src_char];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_oe    <= 1'b0;
            port_out   <= '0;
            selected   <= 1'b0;
            io_pending <= 1'b0;
            src_hi     <= 1'b0;
            src_reg    <= '0;
            src_char   <= '0;
            opa        <= WRM;
            data       <= '{default: '0};
            status     <= '{default: '0};
        end else begin
            data_oe  <= rd_now;
            data_out <= rd_now ? rd_val : '0;
            if (abort) begin
                io_pending <= 1'b0;
                src_hi     <= 1'b0;
            end else if (go) begin
                if (phase == M2 && cm_ram) begin
                    io_pending <= 1'b1;
                    opa        <= ioram_opa_t'(data_in);
                end
                if (phase == X2 && !io_pending && cm_ram) begin
                    selected <= src_hi_in.chip == Chip_id;
                    src_reg  <= src_hi_in.rreg;
                    src_hi   <= 1'b1;
                end
                if (phase == X2 && exec && ram_opa_is_write(opa)) begin
                    if (opa == WRM) data[src_reg][src_char] <= data_in;
                    if (opa == WMP) port_out <= data_in;
                    if (opa[3:2] == 2'b01) status[src_reg][opa[1:0]] <= data_in;
                end
                if (phase == X3) begin
                    io_pending <= 1'b0;
                    src_hi     <= 1'b0;
                    if (src_hi && selected) src_char <= data_in;
                end
            end
        end
    end
endmodule
